// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// VGA timing generator (640x480@60 by default). Divides the system clock into
// a pixel-rate enable, runs horizontal/vertical position counters, and drives
// registered sync, display-enable and coordinate outputs for the colour stage.
//
// Ports:
//   clock        in   1   system clock, all logic on posedge
//   res          in   1   asynchronous active-low reset
//   hsync        out  1   horizontal sync (asserted level = SYNC_POL)
//   vsync        out  1   vertical sync (asserted level = SYNC_POL)
//   de           out  1   display enable, high inside the visible area
//   x            out  10  current horizontal position
//   y            out  10  current vertical position
//   frame_start  out  1   (VGA_FRAME_PULSE_EN only) one-clock pulse when the
//                         counters wrap to (0,0)
//   pixel_tick   out  1   one-clock pulse aligned with each new x/y
//
// Optional feature macro: VGA_FRAME_PULSE_EN adds the frame_start output.
//
// H_ACTIVE+H_FP+H_SYNC+H_BP and the vertical equivalent must not exceed 1024,
// since the position counters are 10 bits wide.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clock,
    input  logic       res,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
`ifdef VGA_FRAME_PULSE_EN
    output logic       frame_start,
`endif
    output logic       pixel_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A one-clock divider still needs a 1-bit register to stay legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode boundaries are 11 bits so a sync window ending exactly at 1024
    // still compares correctly against the zero-extended 10-bit counters.
    localparam logic [10:0] H_DE_END   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SY_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SY_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_DE_END   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SY_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SY_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hpos;
    logic [9:0]       r_vpos;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [9:0]       w_hpos_nxt;
    logic [9:0]       w_vpos_nxt;
    logic [10:0]      w_hpos_ext;
    logic [10:0]      w_vpos_ext;
    logic             w_de_nxt;
    logic             w_hs_on;
    logic             w_vs_on;

    // Pixel-rate divider and counter next-state.
    always_comb begin
        w_tick     = (r_div == DIV_LAST);
        w_div_nxt  = w_tick ? '0 : r_div + 1'b1;
        w_h_wrap   = w_tick && (r_hpos == H_LAST);
        w_v_wrap   = w_h_wrap && (r_vpos == V_LAST);

        w_hpos_nxt = r_hpos;
        if (w_tick) begin
            w_hpos_nxt = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
        end

        w_vpos_nxt = r_vpos;
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? 10'd0 : r_vpos + 10'd1;
        end
    end

    // Outputs are decoded from the next counter values so that, once
    // registered, they always describe the position shown on x/y.
    always_comb begin
        w_hpos_ext = {1'b0, w_hpos_nxt};
        w_vpos_ext = {1'b0, w_vpos_nxt};
        w_de_nxt   = (w_hpos_ext < H_DE_END) && (w_vpos_ext < V_DE_END);
        w_hs_on    = (w_hpos_ext >= H_SY_START) && (w_hpos_ext < H_SY_END);
        w_vs_on    = (w_vpos_ext >= V_SY_START) && (w_vpos_ext < V_SY_END);
    end

    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            r_div  <= '0;
            r_hpos <= 10'd0;
            r_vpos <= 10'd0;
        end else begin
            r_div  <= w_div_nxt;
            r_hpos <= w_hpos_nxt;
            r_vpos <= w_vpos_nxt;
        end
    end

    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            x          <= 10'd0;
            y          <= 10'd0;
            de         <= 1'b0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            pixel_tick <= 1'b0;
        end else begin
            x          <= w_hpos_nxt;
            y          <= w_vpos_nxt;
            de         <= w_de_nxt;
            hsync      <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            vsync      <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            pixel_tick <= w_tick;
        end
    end

`ifdef VGA_FRAME_PULSE_EN
    // Only a real wrap raises the pulse; reset already sits at (0,0) without
    // wrapping, so release never produces one.
    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_v_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Directed bench for vga_sync_gen. dut0 uses the default 640x480 timing with
// CLK_DIV=4 and active-low sync. dut1 uses CLK_DIV=1, active-high sync and a
// shortened 8-line frame (V 4/1/2/1) so frame wrap fits in a short run.
// Positions are sampled 1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic       clock;
    logic       res0;
    logic       res1;

    logic       hs0, vs0, de0, pt0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, de1, pt1;
    logic [9:0] x1, y1;
`ifdef VGA_FRAME_PULSE_EN
    logic       fs0, fs1;
`endif

    int total = 0;
    int bad   = 0;

    vga_sync_gen u_dut0 (
        .clock       (clock),
        .res         (res0),
        .hsync       (hs0),
        .vsync       (vs0),
        .de          (de0),
        .x           (x0),
        .y           (y0),
`ifdef VGA_FRAME_PULSE_EN
        .frame_start (fs0),
`endif
        .pixel_tick  (pt0)
    );

    vga_sync_gen #(
        .CLK_DIV  (1),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) u_dut1 (
        .clock       (clock),
        .res         (res1),
        .hsync       (hs1),
        .vsync       (vs1),
        .de          (de1),
        .x           (x1),
        .y           (y1),
`ifdef VGA_FRAME_PULSE_EN
        .frame_start (fs1),
`endif
        .pixel_tick  (pt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n posedges, then step just past the edge to sample.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Full snapshot of dut0 outputs.
    task automatic check0(input string tag, input int ex, input int ey,
                          input bit ede, input bit ehs, input bit evs, input bit ept);
        checkOutput({tag, ".x"},  32'(x0),  32'(ex));
        checkOutput({tag, ".y"},  32'(y0),  32'(ey));
        checkOutput({tag, ".de"}, 32'(de0), 32'(ede));
        checkOutput({tag, ".hs"}, 32'(hs0), 32'(ehs));
        checkOutput({tag, ".vs"}, 32'(vs0), 32'(evs));
        checkOutput({tag, ".pt"}, 32'(pt0), 32'(ept));
    endtask

    task automatic check1(input string tag, input int ex, input int ey,
                          input bit ede, input bit ehs, input bit evs, input bit ept);
        checkOutput({tag, ".x"},  32'(x1),  32'(ex));
        checkOutput({tag, ".y"},  32'(y1),  32'(ey));
        checkOutput({tag, ".de"}, 32'(de1), 32'(ede));
        checkOutput({tag, ".hs"}, 32'(hs1), 32'(ehs));
        checkOutput({tag, ".vs"}, 32'(vs1), 32'(evs));
        checkOutput({tag, ".pt"}, 32'(pt1), 32'(ept));
    endtask

    initial begin
        res0 = 1'b1;
        res1 = 1'b1;
        #1;
        res0 = 1'b0;
        res1 = 1'b0;
        #1;
        $display("[TB] reset values, before any clock edge");
        check0("rst0", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check1("rst1", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("rst0.fs", 32'(fs0), 32'd0);
`endif

        // ---------------- dut0: default timing, CLK_DIV=4 -----------------
        repeat (3) @(posedge clock);
        @(negedge clock);
        res0 = 1'b1;
        applyStimulus(1);
        check0("rel.e1", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(2);
        check0("rel.e3", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1);
        check0("rel.e4", 1, 0, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("rel.fs", 32'(fs0), 32'd0);
`endif
        applyStimulus(1);
        check0("rel.e5", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(3);
        check0("rel.e8", 2, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        $display("[TB] dut0 horizontal line");
        applyStimulus(2548);
        check0("x639", 639, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(4);
        check0("x640", 640, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(60);
        check0("x655", 655, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(4);
        check0("x656", 656, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(380);
        check0("x751", 751, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(4);
        check0("x752", 752, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(188);
        check0("x799", 799, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(4);
        check0("wrapY1", 0, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1200);
        check0("x300y1", 300, 1, 1'b1, 1'b1, 1'b1, 1'b1);

        $display("[TB] dut0 mid-line reset");
        res0 = 1'b0;
        #1;
        check0("midRst", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #2;
        check0("midRstHeld", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        res0 = 1'b1;
        applyStimulus(1);
        check0("rel2.e1", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(3);
        check0("rel2.e4", 1, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // ------- dut1: CLK_DIV=1, SYNC_POL=1, 800x8 frame ----------------
        $display("[TB] dut1 fast divider, active-high sync, short frame");
        @(negedge clock);
        res1 = 1'b1;
        applyStimulus(1);
        check1("d1.e1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(654);
        check1("d1.x655", 655, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1);
        check1("d1.x656", 656, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(95);
        check1("d1.x751", 751, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1);
        check1("d1.x752", 752, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(47);
        check1("d1.x799", 799, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1);
        check1("d1.line", 0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(2239);
        check1("d1.x639y3", 639, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(161);
        check1("d1.y4", 0, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(799);
        check1("d1.x799y4", 799, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1);
        check1("d1.y5", 0, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1599);
        check1("d1.x799y6", 799, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1);
        check1("d1.y7", 0, 7, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(799);
        check1("d1.last", 799, 7, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("d1.last.fs", 32'(fs1), 32'd0);
`endif
        applyStimulus(1);
        check1("d1.frame", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("d1.frame.fs", 32'(fs1), 32'd1);
`endif
        applyStimulus(1);
        check1("d1.frame+1", 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("d1.frame+1.fs", 32'(fs1), 32'd0);
`endif
        applyStimulus(6399);
        check1("d1.frame2", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("d1.frame2.fs", 32'(fs1), 32'd1);
`endif

        $display("[TB] dut1 reset inside both sync pulses");
        applyStimulus(4700);
        check1("d1.x700y5", 700, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        res1 = 1'b0;
        #1;
        check1("d1.midRst", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef VGA_FRAME_PULSE_EN
        checkOutput("d1.midRst.fs", 32'(fs1), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
